// File: rtl/clock_ctrl.sv
// BCD time-of-day keeper with a button-driven set-mode state machine.
// Produces the digit word, separator blink and display enable for drv_7seg.
module clock_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [31:0] in_num,
  output logic        clock_mode,
  output logic        dot_clk,
  output logic        turn_on,
  output logic [1:0]  set_mode
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    hh, mm, ss, hh_n, mm_n, ss_n;
  logic          mode_q, up_q, down_q;
  logic          mode_e, up_e, down_e, tick, half;

  // Two-digit BCD increment/decrement with wrap at the field limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h00) return top;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign mode_e = btn_mode & ~mode_q;
  assign up_e   = btn_up & ~up_q;
  assign down_e = btn_down & ~down_q;
  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign half   = (presc < PW'(TICK_DIV / 2));

  always_comb begin
    state_n = state;
    hh_n    = hh;
    mm_n    = mm;
    ss_n    = ss;
    presc_n = tick ? '0 : presc + PW'(1);
    if (state == RUN) begin
      if (tick) begin
        ss_n = bcd_inc(ss, 8'h59);
        if (ss == 8'h59) begin
          mm_n = bcd_inc(mm, 8'h59);
          if (mm == 8'h59) hh_n = bcd_inc(hh, 8'h23);
        end
      end
    end else if (!mode_e && (up_e ^ down_e)) begin
      // Only the selected field moves; no carry into neighbours while setting.
      case (state)
        SET_HR:  hh_n = up_e ? bcd_inc(hh, 8'h23) : bcd_dec(hh, 8'h23);
        SET_MIN: mm_n = up_e ? bcd_inc(mm, 8'h59) : bcd_dec(mm, 8'h59);
        SET_SEC: ss_n = up_e ? bcd_inc(ss, 8'h59) : bcd_dec(ss, 8'h59);
        default: ;
      endcase
    end
    if (mode_e) begin
      case (state)
        RUN:     state_n = SET_HR;
        SET_HR:  state_n = SET_MIN;
        SET_MIN: state_n = SET_SEC;
        default: begin
          state_n = RUN;
          presc_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      presc  <= '0;
      hh     <= 8'h00;
      mm     <= 8'h00;
      ss     <= 8'h00;
      mode_q <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      hh     <= hh_n;
      mm     <= mm_n;
      ss     <= ss_n;
      mode_q <= btn_mode;
      up_q   <= btn_up;
      down_q <= btn_down;
    end
  end

  assign in_num     = {hh, 4'h0, mm, 4'h0, ss};
  assign clock_mode = 1'b1;
  assign dot_clk    = (state == RUN) ? half : 1'b1;
  assign turn_on    = (state == RUN) ? 1'b1 : half;
  assign set_mode   = state;

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Time-keeping and set-mode controller for the 7-segment digital clock. It keeps hours, minutes and seconds as BCD and runs a small mode state machine driven by front-panel buttons. It generates the 32-bit digit word, the separator blink and the display enable that feed `drv_7seg`. It sits between the debounced button inputs and `drv_7seg`, and owns everything the driver displays in clock mode.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per second. Must be even and ≥ 4. Benches use 10.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `btn_mode`  in  1  debounced, `clk`-synchronous level; each rising edge advances the mode.
- `btn_up`  in  1  debounced, synchronous level; each rising edge increments the selected field.
- `btn_down`  in  1  debounced, synchronous level; each rising edge decrements the selected field.
- `in_num`  out  32  digit word for `drv_7seg`:
  - [31:24] hours BCD
  - [23:20] 4'h0
  - [19:12] minutes BCD
  - [11:8] 4'h0
  - [7:0] seconds BCD
- `clock_mode`  out  1  constant 1; separators are enabled.
- `dot_clk`  out  1  separator blink.
- `turn_on`  out  1  display enable; blinks in the set states.
- `set_mode`  out  2  current state encoding, for LEDs: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.

## Operation
- **Registers:**
  - `presc`, width $clog2(TICK_DIV), counts 0..TICK_DIV-1 and wraps.
  - `hh` as two BCD nibbles, range 00..23.
  - `mm` and `ss` as two BCD nibbles each, range 00..59.
  - 2-bit state.
  - Three registered previous-level flops, one per button, for edge detection.
- **Edge detection:** an edge is `btn & ~btn_q`. A level held high produces exactly one edge.
- **State machine:** a `btn_mode` edge moves RUN → SET_HR → SET_MIN → SET_SEC → RUN.
- **RUN:**
  - `tick` = (`presc` == TICK_DIV-1).
  - On `tick`, `ss` increments. 59 → 00 carries into `mm`; 59 → 00 carries into `hh`; 23 → 00 wraps.
  - All carries resolve in the same edge, so 23:59:59 → 00:00:00 in one cycle.
  - `btn_up` and `btn_down` edges are ignored.
- **SET_x:**
  - `tick` is ignored and time does not advance.
  - A `btn_up` edge increments only the selected field, with wrap (hh 23 → 00, mm/ss 59 → 00). There is no carry into other fields.
  - A `btn_down` edge decrements only the selected field, with wrap (00 → 23 or 00 → 59).
- **Simultaneous events:**
  - A mode edge together with an up or down edge: the mode change wins and the up/down edge is discarded.
  - Up and down edges in the same cycle: both are discarded.
- **`presc` behaviour:** free-running in every state. It is cleared to 0 on the transition SET_SEC → RUN, so the first second after setting lasts exactly TICK_DIV cycles.
- **Outputs:** all combinational from registers only, with no input-to-output paths.
  - `dot_clk`: (`presc` < TICK_DIV/2) in RUN; constant 1 in SET states.
  - `turn_on`: 1 in RUN; (`presc` < TICK_DIV/2) in SET states.
- **BCD rule:** nibbles never hold values above 9. Increment and decrement operate on the two-digit value with BCD digit carry/borrow, never binary.

## Timing
- **Reset (`reset` = 0, asynchronous):**
  - state RUN, `presc` 0, time 00:00:00, edge flops 0.
  - Outputs: `in_num` 32'h0, `clock_mode` 1, `dot_clk` 1, `turn_on` 1, `set_mode` 0.
- **Reset released mid-second or mid-set:** all progress is lost and operation restarts from the reset values.
- **Input latency:** a button edge sampled at clock edge N updates state or time at edge N; the new value is visible on outputs after edge N.
- **Tick latency:** `ss` changes at the edge where `presc` wraps from TICK_DIV-1 to 0. Seconds period is exactly TICK_DIV cycles.
- **`dot_clk` duty:** high for TICK_DIV/2 cycles starting at the `presc` wrap, then low for TICK_DIV/2.

## Test plan
- **Reset and free run:** TICK_DIV=10; release reset, run 10 cycles. `in_num` = 32'h0000_0001 after the 10th edge, and `dot_clk` pattern 5 high / 5 low.
- **Full rollover:** preload 23:59:59 through SET mode, return to RUN, wait 10 cycles. `in_num` goes 32'h2305_9059 → 32'h0000_0000 in a single edge.
- **Set-mode walk:**
  - Mode edge ×1 then up ×3 → hh = 03.
  - Mode edge, then down ×1 → mm = 59.
  - Mode edge ×2 → RUN, with `set_mode` 0, 1, 2, 3, 0 along the walk.
  - Time frozen throughout set mode; `turn_on` blinking 5/5 while in set mode.
- **Field wrap without carry:** in SET_SEC with ss = 59, up edge → ss = 00 while mm is unchanged. In SET_HR with hh = 00, down edge → 23.
- **Simultaneous and held inputs:**
  - Mode and up in the same cycle → state advances and the field is unchanged.
  - Up and down together → no change.
  - `btn_up` held 50 cycles → exactly +1.
- **Async reset mid-set:** assert `reset`=0 asynchronously (between clock edges) while in SET_MIN with 12:34:00. All outputs reach their reset values immediately without a clock edge.
